cnt_state_ctrl: RTL

CNT_STATE_CTRL -- requirements
Module: cnt_state_ctrl

---
 rtl/cnt_state_ctrl.sv | 67 ++++++
 1 files changed

// File: rtl/cnt_state_ctrl.sv
// cnt_state_ctrl: command-driven state register for counter output logic, with registered load value and change pulse.
// Optional freeze input enabled by defining CNT_STATE_HOLD_EN.
module cnt_state_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       load,
    input  logic       inc,
    input  logic       dec,
`ifdef CNT_STATE_HOLD_EN
    input  logic       hold,
`endif
    input  logic [7:0] d_in,
    output logic [2:0] state,
    output logic [7:0] d_load,
    output logic       chg
);
    typedef enum logic [2:0] {
        IDLE = 3'b000,
        LOAD = 3'b001,
        INC  = 3'b010,
        INC2 = 3'b011,
        DEC  = 3'b100,
        DEC2 = 3'b101
    } state_t;

    state_t state_q, state_nx;
    logic   frz, bad, take;

`ifdef CNT_STATE_HOLD_EN
    assign frz = hold;
`else
    assign frz = 1'b0;
`endif

    assign bad   = state_q > DEC2;
    assign take  = !bad && !clr && !frz && load;
    assign state = state_q;

    // Illegal codes recover to IDLE ahead of every command; clr beats freeze.
    always_comb begin
        state_nx = state_q;
        if (bad || clr)
            state_nx = IDLE;
        else if (frz)
            state_nx = state_q;
        else if (load)
            state_nx = LOAD;
        else if (inc && !dec)
            state_nx = (state_q == INC) ? INC2 : INC;
        else if (dec && !inc)
            state_nx = (state_q == DEC) ? DEC2 : DEC;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            d_load  <= 8'h00;
            chg     <= 1'b0;
        end else begin
            state_q <= state_nx;
            chg     <= state_nx != state_q;
            if (take)
                d_load <= d_in;
        end
    end
endmodule
